// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns debounced 4x4 key levels into a queue of key codes.
// New presses are captured on tick strobes, held in a pending mask, and moved
// into a small FIFO lowest index first, one per clock. A single held key also
// produces auto-repeat codes, which rank below fresh presses.
module key_event_ctrl #(
  parameter int DEPTH     = 4,
  parameter int RPT_DELAY = 32,
  parameter int RPT_RATE  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] btn_flat,
  input  logic        tick,
  output logic [3:0]  code,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        overflow,
  output logic        any_down
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] DELAY_CNT = CW'(RPT_DELAY);
  localparam logic [CW-1:0] RATE_CNT  = CW'(RPT_RATE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [15:0]   prev_reg, pending_reg, pending_next;
  logic          any_down_reg;
  logic          overflow_reg, overflow_next;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  rpt_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]    key_reg, key_next;
  logic          slot_vld_reg, slot_vld_next;
  logic [3:0]    slot_code_reg, slot_code_next;

  logic [15:0] rise, clr_mask, lost_bit, key_mask;
  logic        pop, space, push, lost_rpt, rpt_fire, single_down;
  logic [3:0]  push_code;

  // Rising edges only count on tick cycles.
  assign rise = tick ? (btn_flat & ~prev_reg) : 16'd0;

  // A new press on a key whose previous press is still pending (and not being
  // scheduled this cycle) is a lost event; the pending bit simply stays set.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pend
      assign pending_next[gi] = (pending_reg[gi] & ~clr_mask[gi]) | rise[gi];
      assign lost_bit[gi]     = rise[gi] & pending_reg[gi] & ~clr_mask[gi];
    end
  endgenerate

  assign code_valid  = (count_reg != '0);
  assign code        = code_valid ? mem[rd_ptr_reg] : 4'd0;
  assign pop         = code_valid & code_ready;
  assign space       = (count_reg != FULL_CNT) | pop;
  assign overflow    = overflow_reg;
  assign any_down    = any_down_reg;
  assign key_mask    = 16'd1 << key_reg;
  assign single_down = (btn_flat != 16'd0) && ((btn_flat & (btn_flat - 16'd1)) == 16'd0);
  assign cnt_inc     = cnt_reg + CW'(1);

  // Auto-repeat FSM: next state, counter, latched key and repeat fire strobe.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    key_next   = key_reg;
    rpt_fire   = 1'b0;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (single_down) begin
            state_next = DELAY;
            cnt_next   = '0;
            key_next   = lowest_idx(btn_flat);
          end
        end
        DELAY: begin
          if (btn_flat != key_mask) begin
            state_next = IDLE;
          end else if (cnt_inc == DELAY_CNT) begin
            rpt_fire   = 1'b1;
            state_next = REPEAT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        REPEAT: begin
          if (btn_flat != key_mask) begin
            state_next = IDLE;
          end else if (cnt_inc == RATE_CNT) begin
            rpt_fire = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Scheduler: pending presses first, then the repeat slot; one push per cycle.
  always_comb begin
    push           = 1'b0;
    push_code      = 4'd0;
    clr_mask       = 16'd0;
    lost_rpt       = 1'b0;
    slot_vld_next  = slot_vld_reg;
    slot_code_next = slot_code_reg;
    if (pending_reg != 16'd0 && space) begin
      push      = 1'b1;
      push_code = lowest_idx(pending_reg);
      clr_mask  = 16'd1 << push_code;
    end else if (slot_vld_reg && space) begin
      push          = 1'b1;
      push_code     = slot_code_reg;
      slot_vld_next = 1'b0;
    end
    // A waiting repeat is dropped if the FIFO cannot take anything this cycle.
    if (slot_vld_reg && !space) begin
      lost_rpt      = 1'b1;
      slot_vld_next = 1'b0;
    end
    // A fresh repeat displaces one that is still waiting.
    if (rpt_fire) begin
      if (slot_vld_next) lost_rpt = 1'b1;
      slot_vld_next  = 1'b1;
      slot_code_next = key_reg;
    end
    overflow_next = overflow_reg | (|lost_bit) | lost_rpt;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // State registers with synchronous active-low reset; tick ignored in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_reg      <= 16'd0;
      pending_reg   <= 16'd0;
      any_down_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      key_reg       <= 4'd0;
      slot_vld_reg  <= 1'b0;
      slot_code_reg <= 4'd0;
    end else begin
      if (tick) begin
        prev_reg     <= btn_flat;
        any_down_reg <= |btn_flat;
      end
      pending_reg   <= pending_next;
      overflow_reg  <= overflow_next;
      count_reg     <= count_next;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      key_reg       <= key_next;
      slot_vld_reg  <= slot_vld_next;
      slot_code_reg <= slot_code_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr_reg] <= push_code;
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: per-scenario tasks with a code scoreboard.
module tb_key_event_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] btn_flat;
  logic        tick;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready;
  logic        overflow;
  logic        any_down;

  int          checks;
  int          errors;
  logic [3:0]  sb[$];

  key_event_ctrl #(.DEPTH(4), .RPT_DELAY(32), .RPT_RATE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_flat   (btn_flat),
    .tick       (tick),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overflow   (overflow),
    .any_down   (any_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; btn_flat = 16'd0; tick = 1'b0; code_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_flat = 16'hFFFF; tick = 1'b1; code_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", code_valid); end
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (any_down !== 1'b0) begin errors++; $display("FAIL reset_any_down: got %b want 0", any_down); end
    rst_n = 1'b1; btn_flat = 16'd0; tick = 1'b0; code_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_press();
    int pops = 0;
    logic [3:0] exp_code;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      btn_flat = 16'h0020; tick = (i == 0); code_ready = 1'b1;
      if (i == 0) sb.push_back(4'd5);
      if (i == 1) begin
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid %b want 0", code_valid); end
        checks++; if (any_down !== 1'b1) begin errors++; $display("FAIL single_any_down: got %b want 1", any_down); end
      end
      if (i == 2) begin
        checks++;
        if (code_valid !== 1'b1 || code !== 4'd5) begin
          errors++; $display("FAIL single_latency: valid %b code %0d want valid 1 code 5", code_valid, code);
        end
      end
      if (code_valid && code_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL single_pop: code %0d with nothing expected", code); end
        else begin
          exp_code = sb.pop_front();
          if (code !== exp_code) begin errors++; $display("FAIL single_pop: code %0d want %0d", code, exp_code); end
        end
        $display("single: pop code=%0d cycle %0d", code, i);
        pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops != 1) begin errors++; $display("FAIL single_count: pops %0d want 1", pops); end
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL single_drained: valid %b want 0", code_valid); end
  endtask

  task automatic test_simultaneous();
    int pops = 0;
    int first_at = -1;
    int last_at = -1;
    logic [3:0] exp_code;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_flat = 16'h8011; tick = (i == 0); code_ready = 1'b1;
      if (i == 0) begin sb.push_back(4'd0); sb.push_back(4'd4); sb.push_back(4'd15); end
      if (code_valid && code_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL simul_pop: code %0d with nothing expected", code); end
        else begin
          exp_code = sb.pop_front();
          if (code !== exp_code) begin errors++; $display("FAIL simul_pop: code %0d want %0d", code, exp_code); end
        end
        $display("simul: pop code=%0d cycle %0d", code, i);
        if (first_at < 0) first_at = i;
        last_at = i;
        pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops != 3) begin errors++; $display("FAIL simul_count: pops %0d want 3", pops); end
    checks++; if (first_at != 2 || last_at != 4) begin errors++; $display("FAIL simul_timing: cycles %0d..%0d want 2..4", first_at, last_at); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_fifo_full();
    int pops = 0;
    int first_at = -1;
    int last_at = -1;
    logic [3:0] exp_code;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      btn_flat = 16'h003F; tick = (i == 0); code_ready = (i >= 12);
      if (i == 0) for (int k = 0; k < 6; k++) sb.push_back(4'(k));
      if (i == 10) begin
        checks++;
        if (code_valid !== 1'b1 || code !== 4'd0) begin
          errors++; $display("FAIL full_head: valid %b code %0d want valid 1 code 0", code_valid, code);
        end
      end
      if (code_valid && code_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL full_pop: code %0d with nothing expected", code); end
        else begin
          exp_code = sb.pop_front();
          if (code !== exp_code) begin errors++; $display("FAIL full_pop: code %0d want %0d", code, exp_code); end
        end
        $display("full: pop code=%0d cycle %0d", code, i);
        if (first_at < 0) first_at = i;
        last_at = i;
        pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops != 6) begin errors++; $display("FAIL full_count: pops %0d want 6", pops); end
    checks++; if (first_at != 12 || last_at != 17) begin errors++; $display("FAIL full_timing: cycles %0d..%0d want 12..17", first_at, last_at); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_auto_repeat();
    int pops = 0;
    int pop_at[$];
    int exp_at[5] = '{2, 130, 162, 194, 210};
    logic [3:0] exp_code;
    do_reset();
    for (int i = 0; i < 248; i++) begin
      btn_flat = (i < 208) ? 16'h0200 : 16'h0201;
      tick = ((i % 4) == 0);
      code_ready = 1'b1;
      // Tick numbers 0, 32, 40, 48 give key 9; tick 52 adds a press of key 0.
      if (i == 0 || i == 128 || i == 160 || i == 192) sb.push_back(4'd9);
      if (i == 208) sb.push_back(4'd0);
      if (code_valid && code_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL repeat_pop: code %0d with nothing expected", code); end
        else begin
          exp_code = sb.pop_front();
          if (code !== exp_code) begin errors++; $display("FAIL repeat_pop: code %0d want %0d", code, exp_code); end
        end
        $display("repeat: pop code=%0d cycle %0d", code, i);
        pop_at.push_back(i);
        pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops != 5) begin errors++; $display("FAIL repeat_count: pops %0d want 5", pops); end
    for (int k = 0; k < 5 && k < pop_at.size(); k++) begin
      checks++;
      if (pop_at[k] != exp_at[k]) begin errors++; $display("FAIL repeat_timing: event %0d at cycle %0d want %0d", k, pop_at[k], exp_at[k]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL repeat_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_loss();
    int pops = 0;
    logic [3:0] exp_code;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i < 4)       btn_flat = 16'h0017;
      else if (i < 8)  btn_flat = 16'h001F;
      else if (i < 12) btn_flat = 16'h0017;
      else             btn_flat = 16'h001F;
      tick = ((i % 4) == 0);
      code_ready = (i >= 16);
      if (i == 0) begin sb.push_back(4'd0); sb.push_back(4'd1); sb.push_back(4'd2); sb.push_back(4'd4); end
      if (i == 4) sb.push_back(4'd3);
      if (i == 10) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL loss_early: overflow %b want 0", overflow); end
      end
      if (i == 14) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL loss_flag: overflow %b want 1", overflow); end
      end
      if (code_valid && code_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL loss_pop: code %0d with nothing expected", code); end
        else begin
          exp_code = sb.pop_front();
          if (code !== exp_code) begin errors++; $display("FAIL loss_pop: code %0d want %0d", code, exp_code); end
        end
        $display("loss: pop code=%0d cycle %0d", code, i);
        pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops != 5) begin errors++; $display("FAIL loss_count: pops %0d want 5", pops); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL loss_sticky: overflow %b want 1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL loss_clear: overflow %b want 0 after reset", overflow); end
  endtask

  task automatic test_reset_mid_queue();
    int pops = 0;
    logic [3:0] exp_code;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn_flat = 16'h000E;
      rst_n = (i != 6);
      tick = (i == 0) || (i == 6) || (i == 8);
      code_ready = (i >= 8);
      if (i == 0) begin sb.push_back(4'd1); sb.push_back(4'd2); sb.push_back(4'd3); end
      if (i == 5) begin
        checks++;
        if (code_valid !== 1'b1 || code !== 4'd1) begin
          errors++; $display("FAIL midrst_queued: valid %b code %0d want valid 1 code 1", code_valid, code);
        end
      end
      if (i == 7) begin
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", code_valid); end
        checks++; if (code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d want 0", code); end
        checks++; if (any_down !== 1'b0) begin errors++; $display("FAIL midrst_any_down: got %b want 0", any_down); end
        sb.delete();
      end
      if (i == 8) begin sb.push_back(4'd1); sb.push_back(4'd2); sb.push_back(4'd3); end
      if (code_valid && code_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL midrst_pop: code %0d with nothing expected", code); end
        else begin
          exp_code = sb.pop_front();
          if (code !== exp_code) begin errors++; $display("FAIL midrst_pop: code %0d want %0d", code, exp_code); end
        end
        $display("midrst: pop code=%0d cycle %0d", code, i);
        pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops != 3) begin errors++; $display("FAIL midrst_count: pops %0d want 3", pops); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL midrst_left: %0d codes never seen, want 0", sb.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; btn_flat = 16'd0; tick = 1'b0; code_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_simultaneous();
    test_fifo_full();
    test_auto_repeat();
    test_loss();
    test_reset_mid_queue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
